// File: rtl/rv_writeback_pkg.sv
// Purpose : shared definitions for the writeback stage.
//           Load/store funct3 width codes, writeback FSM encodings and
//           the latched context of an outstanding load.
// Ports   : none (package).
package rv_writeback_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned REG_W = 5;
   localparam int unsigned FUN_W = 3;

   // funct3 width codes for loads and stores
   localparam logic [FUN_W-1:0] LDST_B  = 3'b000;
   localparam logic [FUN_W-1:0] LDST_H  = 3'b001;
   localparam logic [FUN_W-1:0] LDST_L  = 3'b010;
   localparam logic [FUN_W-1:0] LDST_BU = 3'b100;
   localparam logic [FUN_W-1:0] LDST_HU = 3'b101;

   typedef enum logic [1:0] {
      WB_IDLE       = 2'd0,
      WB_WAIT_LOAD  = 2'd1,
      WB_WAIT_STORE = 2'd2
   } wb_state_e;

   // Fields of a load that must survive until its data returns
   typedef struct packed {
      logic [REG_W-1:0] rd;
      logic [FUN_W-1:0] fun;
      logic [1:0]       addr_lo;
   } ld_ctx_t;

endpackage : rv_writeback_pkg

// File: rtl/rv_writeback_if.sv
// Purpose : execute-bundle and data-memory response bus feeding writeback.
// Ports   : master drives (execute stage + data memory side),
//           slave receives (writeback stage).
//   x_fun_i        funct3 of the load/store
//   x_load_i       valid load in stage
//   x_store_i      valid store in stage
//   x_rd_i         destination register
//   x_rd_value_i   ALU result for non-load writes
//   x_rd_write_i   ALU-result write request
//   x_dm_addr_i    data-memory address of load/store
//   dm_data_l_i    load data from memory
//   dm_load_done_i load data valid this cycle
//   dm_store_done_i store accepted this cycle
interface rv_writeback_if;
   import rv_writeback_pkg::*;

   logic [FUN_W-1:0] x_fun_i;
   logic             x_load_i;
   logic             x_store_i;
   logic [REG_W-1:0] x_rd_i;
   logic [XLEN-1:0]  x_rd_value_i;
   logic             x_rd_write_i;
   logic [XLEN-1:0]  x_dm_addr_i;
   logic [XLEN-1:0]  dm_data_l_i;
   logic             dm_load_done_i;
   logic             dm_store_done_i;

   modport master (
      output x_fun_i, x_load_i, x_store_i, x_rd_i, x_rd_value_i,
             x_rd_write_i, x_dm_addr_i, dm_data_l_i, dm_load_done_i,
             dm_store_done_i
   );

   modport slave (
      input  x_fun_i, x_load_i, x_store_i, x_rd_i, x_rd_value_i,
             x_rd_write_i, x_dm_addr_i, dm_data_l_i, dm_load_done_i,
             dm_store_done_i
   );

endinterface : rv_writeback_if

// File: rtl/rv_writeback_load_align.sv
// Purpose : combinational load-data extraction and sign/zero extension.
// Ports   :
//   fun_i    funct3 width code
//   addr_i   byte offset (address bits [1:0])
//   data_i   raw 32-bit word returned by memory
//   value_o  extended value to write to the register file
module rv_writeback_load_align
   import rv_writeback_pkg::*;
(
   input  logic [FUN_W-1:0] fun_i,
   input  logic [1:0]       addr_i,
   input  logic [XLEN-1:0]  data_i,
   output logic [XLEN-1:0]  value_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Lane selection; halfwords use only addr[1] (misalignment not trapped)
   always_comb begin
      byte_sel = data_i[7:0];
      case (addr_i)
         2'd0:    byte_sel = data_i[7:0];
         2'd1:    byte_sel = data_i[15:8];
         2'd2:    byte_sel = data_i[23:16];
         default: byte_sel = data_i[31:24];
      endcase
      half_sel = addr_i[1] ? data_i[31:16] : data_i[15:0];
   end

   // Extension; unknown width codes write zero
   always_comb begin
      value_o = '0;
      case (fun_i)
         LDST_B:  value_o = {{24{byte_sel[7]}}, byte_sel};
         LDST_BU: value_o = {24'h0, byte_sel};
         LDST_H:  value_o = {{16{half_sel[15]}}, half_sel};
         LDST_HU: value_o = {16'h0, half_sel};
         LDST_L:  value_o = data_i;
         default: value_o = '0;
      endcase
   end

endmodule : rv_writeback_load_align

// File: rtl/rv_writeback.sv
// Purpose : final pipeline stage. Completes outstanding data-memory
//           transactions, extracts load data and drives the register-file
//           write port one cycle later; requests a stall while a memory
//           response is outstanding and flags transactions that time out.
// Ports   :
//   clk_i          clock, rising edge
//   rst_n_i        asynchronous active-low reset
//   w_stall_i      global pipeline stall
//   w_stall_req_o  stall request (combinational)
//   xb             execute bundle + data-memory response (slave)
//   rf_rd_o        register-file write index (registered, bypass source)
//   rf_rd_value_o  register-file write data (registered, bypass source)
//   rf_rd_write_o  register-file write enable, one-cycle pulse
//   bus_err_o      one-cycle pulse on transaction timeout
// Params  : LOAD_TIMEOUT  max wait cycles for a response; 0 disables.
module rv_writeback
   import rv_writeback_pkg::*;
#(
   parameter int unsigned LOAD_TIMEOUT = 0
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             w_stall_i,
   output logic             w_stall_req_o,
   rv_writeback_if.slave    xb,
   output logic [REG_W-1:0] rf_rd_o,
   output logic [XLEN-1:0]  rf_rd_value_o,
   output logic             rf_rd_write_o,
   output logic             bus_err_o
);

   localparam int unsigned CNT_W  = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
   localparam bit          TO_EN  = (LOAD_TIMEOUT != 0);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_TIMEOUT - 1);

   wb_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   ld_ctx_t          ld_q, ld_d;
   logic [REG_W-1:0] rf_rd_q, rf_rd_d;
   logic [XLEN-1:0]  rf_val_q, rf_val_d;
   logic             rf_we_q, rf_we_d;
   logic             bus_err_q, bus_err_d;
   logic             stall_req_c;

   logic [FUN_W-1:0] al_fun;
   logic [1:0]       al_addr;
   logic [XLEN-1:0]  al_value;

   // Upper address bits only matter to the memory, not to extraction
   logic unused_addr_hi;
   assign unused_addr_hi = ^xb.x_dm_addr_i[XLEN-1:2];

   // Aligner sees the live bundle in IDLE, the latched load while waiting
   always_comb begin
      al_fun  = xb.x_fun_i;
      al_addr = xb.x_dm_addr_i[1:0];
      if (state_q == WB_WAIT_LOAD) begin
         al_fun  = ld_q.fun;
         al_addr = ld_q.addr_lo;
      end
   end

   rv_writeback_load_align u_align (
      .fun_i   (al_fun),
      .addr_i  (al_addr),
      .data_i  (xb.dm_data_l_i),
      .value_o (al_value)
   );

   // State and output registers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= WB_IDLE;
         cnt_q     <= '0;
         ld_q      <= '0;
         rf_rd_q   <= '0;
         rf_val_q  <= '0;
         rf_we_q   <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ld_q      <= ld_d;
         rf_rd_q   <= rf_rd_d;
         rf_val_q  <= rf_val_d;
         rf_we_q   <= rf_we_d;
         bus_err_q <= bus_err_d;
      end
   end

   // Next-state, write-port and stall-request logic
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ld_d        = ld_q;
      rf_rd_d     = rf_rd_q;
      rf_val_d    = rf_val_q;
      rf_we_d     = 1'b0;
      bus_err_d   = 1'b0;
      stall_req_c = 1'b0;

      case (state_q)
         WB_IDLE: begin
            if (!w_stall_i) begin
               if (xb.x_load_i) begin
                  if (xb.dm_load_done_i) begin
                     if (xb.x_rd_i != '0) begin
                        rf_rd_d  = xb.x_rd_i;
                        rf_val_d = al_value;
                        rf_we_d  = 1'b1;
                     end
                  end else begin
                     ld_d        = '{rd: xb.x_rd_i, fun: xb.x_fun_i,
                                     addr_lo: xb.x_dm_addr_i[1:0]};
                     cnt_d       = '0;
                     state_d     = WB_WAIT_LOAD;
                     stall_req_c = 1'b1;
                  end
               end else if (xb.x_store_i) begin
                  if (!xb.dm_store_done_i) begin
                     cnt_d       = '0;
                     state_d     = WB_WAIT_STORE;
                     stall_req_c = 1'b1;
                  end
               end else if (xb.x_rd_write_i && (xb.x_rd_i != '0)) begin
                  rf_rd_d  = xb.x_rd_i;
                  rf_val_d = xb.x_rd_value_i;
                  rf_we_d  = 1'b1;
               end
            end
         end

         // A done in the expiry cycle takes precedence over the timeout
         WB_WAIT_LOAD: begin
            stall_req_c = !xb.dm_load_done_i;
            if (xb.dm_load_done_i) begin
               if (ld_q.rd != '0) begin
                  rf_rd_d  = ld_q.rd;
                  rf_val_d = al_value;
                  rf_we_d  = 1'b1;
               end
               state_d = WB_IDLE;
            end else if (TO_EN && (cnt_q == CNT_LAST)) begin
               bus_err_d = 1'b1;
               state_d   = WB_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         WB_WAIT_STORE: begin
            stall_req_c = !xb.dm_store_done_i;
            if (xb.dm_store_done_i) begin
               state_d = WB_IDLE;
            end else if (TO_EN && (cnt_q == CNT_LAST)) begin
               bus_err_d = 1'b1;
               state_d   = WB_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         default: begin
            state_d = WB_IDLE;
         end
      endcase
   end

   assign w_stall_req_o = stall_req_c;
   assign rf_rd_o       = rf_rd_q;
   assign rf_rd_value_o = rf_val_q;
   assign rf_rd_write_o = rf_we_q;
   assign bus_err_o     = bus_err_q;

endmodule : rv_writeback

// File: tb/tb_rv_writeback.sv
// Directed bench for rv_writeback. Two instances share one input bus:
// dut (LOAD_TIMEOUT=4) and dut0 (timeout disabled).
module tb_rv_writeback;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        w_stall;
   logic        stall_req, stall_req0;
   logic [4:0]  rf_rd, rf_rd0;
   logic [31:0] rf_val, rf_val0;
   logic        rf_we, rf_we0;
   logic        bus_err, bus_err0;

   int n_checks = 0;
   int n_fail   = 0;

   rv_writeback_if xb_if ();

   rv_writeback #(.LOAD_TIMEOUT(4)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .w_stall_i(w_stall),
      .w_stall_req_o(stall_req), .xb(xb_if),
      .rf_rd_o(rf_rd), .rf_rd_value_o(rf_val),
      .rf_rd_write_o(rf_we), .bus_err_o(bus_err)
   );

   rv_writeback #(.LOAD_TIMEOUT(0)) dut0 (
      .clk_i(clk), .rst_n_i(rst_n), .w_stall_i(w_stall),
      .w_stall_req_o(stall_req0), .xb(xb_if),
      .rf_rd_o(rf_rd0), .rf_rd_value_o(rf_val0),
      .rf_rd_write_o(rf_we0), .bus_err_o(bus_err0)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      w_stall                = 1'b0;
      xb_if.x_fun_i          = 3'b000;
      xb_if.x_load_i         = 1'b0;
      xb_if.x_store_i        = 1'b0;
      xb_if.x_rd_i           = 5'd0;
      xb_if.x_rd_value_i     = 32'h0;
      xb_if.x_rd_write_i     = 1'b0;
      xb_if.x_dm_addr_i      = 32'h0;
      xb_if.dm_data_l_i      = 32'h0;
      xb_if.dm_load_done_i   = 1'b0;
      xb_if.dm_store_done_i  = 1'b0;
   endtask

   task automatic drive_load(input logic [4:0] rd, input logic [2:0] fun,
                             input logic [31:0] addr, input logic [31:0] data,
                             input logic done);
      xb_if.x_load_i       = 1'b1;
      xb_if.x_rd_i         = rd;
      xb_if.x_fun_i        = fun;
      xb_if.x_dm_addr_i    = addr;
      xb_if.dm_data_l_i    = data;
      xb_if.dm_load_done_i = done;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clear_inputs();
      #3;
      n_checks++; if (rf_rd !== 5'd0) begin n_fail++; $display("FAIL reset_rd: got %0d want 0", rf_rd); end
      n_checks++; if (rf_val !== 32'h0) begin n_fail++; $display("FAIL reset_val: got %h want 0", rf_val); end
      n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", rf_we); end
      n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus_err); end
      n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall_req); end
      @(negedge clk) rst_n = 1'b1;
      step();
   endtask

   task automatic test_alu();
      xb_if.x_rd_i = 5'd5; xb_if.x_rd_value_i = 32'h1234; xb_if.x_rd_write_i = 1'b1;
      #1;
      n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL alu_stall: got %b want 0", stall_req); end
      step(); clear_inputs();
      n_checks++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL alu_we: got %b want 1", rf_we); end
      n_checks++; if (rf_rd !== 5'd5) begin n_fail++; $display("FAIL alu_rd: got %0d want 5", rf_rd); end
      n_checks++; if (rf_val !== 32'h1234) begin n_fail++; $display("FAIL alu_val: got %h want 00001234", rf_val); end
      step();
      n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL alu_pulse: got %b want 0", rf_we); end
      // rd = 0 never writes
      xb_if.x_rd_i = 5'd0; xb_if.x_rd_value_i = 32'h5555; xb_if.x_rd_write_i = 1'b1;
      step(); clear_inputs();
      n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL alu_rd0_we: got %b want 0", rf_we); end
      // global stall in IDLE blocks acceptance
      xb_if.x_rd_i = 5'd6; xb_if.x_rd_value_i = 32'h66; xb_if.x_rd_write_i = 1'b1; w_stall = 1'b1;
      step();
      n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL alu_wstall_we: got %b want 0", rf_we); end
      w_stall = 1'b0;
      step(); clear_inputs();
      n_checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd6) begin n_fail++; $display("FAIL alu_after_stall: we=%b rd=%0d want 1/6", rf_we, rf_rd); end
      step();
   endtask

   task automatic test_load_same_cycle();
      logic [2:0]  fn  [8];
      logic [31:0] ad  [8];
      logic [31:0] exp_v [8];
      fn    = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b001, 3'b010, 3'b011, 3'b100};
      ad    = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h101, 32'h100, 32'h100, 32'h101};
      exp_v = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF,
                32'hFFFFFF00, 32'h80FFFF00, 32'h00000000, 32'h000000FF};
      for (int i = 0; i < 8; i++) begin
         drive_load(5'(i + 1), fn[i], ad[i], 32'h80FFFF00, 1'b1);
         #1;
         n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL ld%0d_stall: got %b want 0", i, stall_req); end
         step(); clear_inputs();
         n_checks++; if (rf_we !== 1'b1 || rf_rd !== 5'(i + 1) || rf_val !== exp_v[i]) begin
            n_fail++;
            $display("FAIL ld%0d_write: we=%b rd=%0d val=%h want 1/%0d/%h", i, rf_we, rf_rd, rf_val, i + 1, exp_v[i]);
         end
      end
      step();
      n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL ld_pulse: got %b want 0", rf_we); end
   endtask

   task automatic test_load_wait();
      drive_load(5'd9, 3'b010, 32'h200, 32'hDEADBEEF, 1'b0);
      #1;
      n_checks++; if (stall_req !== 1'b1) begin n_fail++; $display("FAIL lw_stall0: got %b want 1", stall_req); end
      step();
      // bundle changes while waiting must be ignored
      xb_if.x_load_i = 1'b0; xb_if.x_rd_i = 5'd3; xb_if.x_fun_i = 3'b000;
      xb_if.x_dm_addr_i = 32'h3; xb_if.x_rd_write_i = 1'b1; xb_if.x_rd_value_i = 32'hBAD;
      for (int c = 1; c < 3; c++) begin
         #1;
         n_checks++; if (stall_req !== 1'b1 || rf_we !== 1'b0) begin
            n_fail++; $display("FAIL lw_wait%0d: stall=%b we=%b want 1/0", c, stall_req, rf_we);
         end
         if (c < 2) step();
      end
      step();
      xb_if.dm_data_l_i = 32'hCAFEF00D; xb_if.dm_load_done_i = 1'b1; w_stall = 1'b1;
      #1;
      n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL lw_done_stall: got %b want 0", stall_req); end
      step(); clear_inputs();
      n_checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd9 || rf_val !== 32'hCAFEF00D) begin
         n_fail++; $display("FAIL lw_write: we=%b rd=%0d val=%h want 1/9/cafef00d", rf_we, rf_rd, rf_val);
      end
      step();
      n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL lw_pulse: got %b want 0", rf_we); end
   endtask

   task automatic test_store();
      xb_if.x_store_i = 1'b1; xb_if.x_rd_i = 5'd4; xb_if.x_rd_write_i = 1'b1; xb_if.x_rd_value_i = 32'h44;
      #1;
      n_checks++; if (stall_req !== 1'b1) begin n_fail++; $display("FAIL st_stall0: got %b want 1", stall_req); end
      step();
      n_checks++; if (stall_req !== 1'b1 || rf_we !== 1'b0) begin n_fail++; $display("FAIL st_wait: stall=%b we=%b want 1/0", stall_req, rf_we); end
      step();
      xb_if.dm_store_done_i = 1'b1;
      #1;
      n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL st_done_stall: got %b want 0", stall_req); end
      step(); clear_inputs();
      n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL st_we: got %b want 0", rf_we); end
      // store completing in the same cycle
      xb_if.x_store_i = 1'b1; xb_if.dm_store_done_i = 1'b1; xb_if.x_rd_i = 5'd4; xb_if.x_rd_write_i = 1'b1;
      #1;
      n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL st_same_stall: got %b want 0", stall_req); end
      step(); clear_inputs();
      n_checks++; if (rf_we !== 1'b0 || stall_req !== 1'b0) begin n_fail++; $display("FAIL st_same: we=%b stall=%b want 0/0", rf_we, stall_req); end
      step();
   endtask

   task automatic test_timeout();
      drive_load(5'd10, 3'b010, 32'h300, 32'h0, 1'b0);
      step(); clear_inputs();
      for (int c = 0; c < 4; c++) begin
         n_checks++; if (stall_req !== 1'b1 || bus_err !== 1'b0) begin
            n_fail++; $display("FAIL to_wait%0d: stall=%b err=%b want 1/0", c, stall_req, bus_err);
         end
         step();
      end
      n_checks++; if (bus_err !== 1'b1 || rf_we !== 1'b0 || stall_req !== 1'b0) begin
         n_fail++; $display("FAIL to_expire: err=%b we=%b stall=%b want 1/0/0", bus_err, rf_we, stall_req);
      end
      // disabled-timeout instance keeps waiting
      n_checks++; if (stall_req0 !== 1'b1 || bus_err0 !== 1'b0) begin
         n_fail++; $display("FAIL nto_wait: stall=%b err=%b want 1/0", stall_req0, bus_err0);
      end
      xb_if.dm_data_l_i = 32'h55AA00FF; xb_if.dm_load_done_i = 1'b1;
      step(); clear_inputs();
      n_checks++; if (bus_err !== 1'b0 || rf_we !== 1'b0) begin n_fail++; $display("FAIL to_after: err=%b we=%b want 0/0", bus_err, rf_we); end
      n_checks++; if (rf_we0 !== 1'b1 || rf_rd0 !== 5'd10 || rf_val0 !== 32'h55AA00FF) begin
         n_fail++; $display("FAIL nto_write: we=%b rd=%0d val=%h want 1/10/55aa00ff", rf_we0, rf_rd0, rf_val0);
      end
      step();
      // done in the expiry cycle wins
      drive_load(5'd11, 3'b010, 32'h304, 32'h0, 1'b0);
      step(); clear_inputs();
      step(); step(); step();
      xb_if.dm_data_l_i = 32'h11223344; xb_if.dm_load_done_i = 1'b1;
      step(); clear_inputs();
      n_checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd11 || rf_val !== 32'h11223344 || bus_err !== 1'b0) begin
         n_fail++; $display("FAIL to_race: we=%b rd=%0d val=%h err=%b want 1/11/11223344/0", rf_we, rf_rd, rf_val, bus_err);
      end
      step();
      n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL to_race_err: got %b want 0", bus_err); end
   endtask

   task automatic test_reset_mid_wait();
      drive_load(5'd13, 3'b010, 32'h400, 32'h0, 1'b0);
      step(); clear_inputs();
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (rf_rd !== 5'd0 || rf_val !== 32'h0 || rf_we !== 1'b0 || stall_req !== 1'b0) begin
         n_fail++; $display("FAIL rst_mid: rd=%0d val=%h we=%b stall=%b want 0/0/0/0", rf_rd, rf_val, rf_we, stall_req);
      end
      step(); step();
      @(negedge clk) rst_n = 1'b1;
      xb_if.dm_data_l_i = 32'h99; xb_if.dm_load_done_i = 1'b1;
      step();
      n_checks++; if (rf_we !== 1'b0 || rf_we0 !== 1'b0) begin n_fail++; $display("FAIL rst_stale: we=%b we0=%b want 0/0", rf_we, rf_we0); end
      clear_inputs();
      xb_if.x_rd_i = 5'd12; xb_if.x_rd_value_i = 32'h77; xb_if.x_rd_write_i = 1'b1;
      step(); clear_inputs();
      n_checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd12 || rf_val !== 32'h77) begin
         n_fail++; $display("FAIL rst_alu: we=%b rd=%0d val=%h want 1/12/77", rf_we, rf_rd, rf_val);
      end
      step();
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load_same_cycle();
      test_load_wait();
      test_store();
      test_timeout();
      test_reset_mid_wait();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_rv_writeback
